// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM with a memory-wait timeout and a sticky bus error.
// Define MC_CTRL_PERF_EN to add the instr_count/cycle_count performance counters.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        instr_done,
`ifdef MC_CTRL_PERF_EN
  output logic [15:0] instr_count,
  output logic [15:0] cycle_count,
`endif
  output logic        bus_err
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [3:0] OP_LW  = 4'd0;
  localparam logic [3:0] OP_SW  = 4'd1;
  localparam logic [3:0] OP_BEQ = 4'd11;
  localparam logic [3:0] OP_BNE = 4'd12;
  localparam logic [3:0] OP_J   = 4'd13;

  localparam logic [7:0] WAIT_MAX   = 8'(MEM_WAIT_MAX);
  localparam bit         TIMEOUT_EN = (MEM_WAIT_MAX != 0);

  logic [2:0] state_q, state_d;
  logic [3:0] op_q;
  logic [7:0] wait_q;
  logic       bus_err_q;
  logic       timeout;

  // A ready on the limit cycle wins because timeout requires !mem_ready.
  assign timeout = TIMEOUT_EN && (wait_q == WAIT_MAX) && !mem_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d != state_q)
        wait_q <= '0;
      else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
        wait_q <= wait_q + 8'd1;
      if (state_d == S_ERR) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE; else if (timeout) state_d = S_ERR;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op_q == OP_LW || op_q == OP_SW) state_d = S_MEM;
        else if (op_q <= 4'd10)             state_d = S_WB;
        else                                state_d = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready)    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        else if (timeout) state_d = S_ERR;
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          if (op_q == OP_LW || op_q == OP_SW) begin
            alu_src = 1'b1;
            alu_op  = 2'b10;
          end else if (op_q <= 4'd10) begin
            alu_op = 2'b00;
          end else begin
            instr_done = 1'b1;
            if (op_q == OP_BEQ || op_q == OP_BNE) begin
              alu_op   = 2'b01;
              pc_src   = 2'b01;
              pc_write = (op_q == OP_BEQ) ? zero : !zero;
            end else if (op_q == OP_J) begin
              pc_src   = 2'b10;
              pc_write = 1'b1;
            end
          end
        end
        S_MEM: begin
          i_or_d     = 1'b1;
          alu_src    = 1'b1;
          alu_op     = 2'b10;
          mem_read   = (op_q == OP_LW);
          mem_write  = (op_q == OP_SW);
          instr_done = mem_ready && (op_q == OP_SW);
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          if (op_q == OP_LW) mem_to_reg = 1'b1;
          else               reg_dst    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = reset ? S_FETCH : state_q;
  assign bus_err = bus_err_q && !reset;

`ifdef MC_CTRL_PERF_EN
  logic [15:0] instr_cnt_q, cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      if (instr_done)       instr_cnt_q <= instr_cnt_q + 16'd1;
      if (state_q != S_ERR) cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  assign instr_count = reset ? 16'd0 : instr_cnt_q;
  assign cycle_count = reset ? 16'd0 : cycle_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle schedules built from the
// instruction rules, driven with random waits/flags and compared cycle by cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, alu_op;
  logic       alu_src, reg_dst, mem_to_reg, instr_done, bus_err;
  logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [15:0] instr_count, cycle_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .state(state), .instr_done(instr_done),
`ifdef MC_CTRL_PERF_EN
    .instr_count(instr_count), .cycle_count(cycle_count),
`endif
    .bus_err(bus_err)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
    logic [1:0] pc_src, alu_op;
    logic       alu_src, reg_dst, mem_to_reg, instr_done, bus_err;
  } obs_t;

  typedef struct {
    logic       rdy;
    logic [3:0] opc;
    logic       zr;
    obs_t       exp;
  } step_t;

  step_t q[$];

  function automatic obs_t sample();
    sample = {state, mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write,
              pc_src, alu_op, alu_src, reg_dst, mem_to_reg, instr_done, bus_err};
  endfunction

  task automatic push(input logic rdy, input logic [3:0] opc, input logic zr, input obs_t e);
    step_t s;
    s.rdy = rdy; s.opc = opc; s.zr = zr; s.exp = e;
    q.push_back(s);
  endtask

  // Expected cycle sequence of one instruction: fw/mw = not-ready cycles in FETCH/MEM.
  task automatic model_instr(input logic [3:0] op, input logic zr, input int fw, input int mw);
    obs_t e;
    bit is_mem, is_dp;
    is_mem = (op == 4'd0 || op == 4'd1);
    is_dp  = (op >= 4'd2 && op <= 4'd10);
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_read = 1'b1;
      push(1'b0, 4'($urandom), 1'($urandom), e);
    end
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b1, 4'($urandom), 1'($urandom), e);
    e = '0; e.state = 3'd1;
    push(1'($urandom), op, 1'($urandom), e);
    e = '0; e.state = 3'd2;
    if (is_mem) begin
      e.alu_src = 1'b1; e.alu_op = 2'b10;
    end else if (!is_dp) begin
      e.instr_done = 1'b1;
      if (op == 4'd11) begin e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_write = zr;  end
      if (op == 4'd12) begin e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_write = !zr; end
      if (op == 4'd13) begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
    end
    push(1'($urandom), 4'($urandom), zr, e);
    if (is_mem) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.state = 3'd3; e.i_or_d = 1'b1; e.alu_src = 1'b1; e.alu_op = 2'b10;
        e.mem_read = (op == 4'd0); e.mem_write = (op == 4'd1);
        e.instr_done = (i == mw) && (op == 4'd1);
        push(i == mw, 4'($urandom), 1'($urandom), e);
      end
    end
    if (op == 4'd0 || is_dp) begin
      e = '0; e.state = 3'd4; e.reg_write = 1'b1; e.instr_done = 1'b1;
      if (op == 4'd0) e.mem_to_reg = 1'b1; else e.reg_dst = 1'b1;
      push(1'($urandom), 4'($urandom), 1'($urandom), e);
    end
  endtask

  // Drives queued steps from a falling edge, checking #1 later; leaves keep entries.
  task automatic run_steps(input string tag, input int keep);
    step_t s;
    obs_t got;
    int idx = 0;
    while (q.size() > keep) begin
      s = q.pop_front();
      mem_ready = s.rdy; opcode = s.opc; zero = s.zr;
      #1;
      got = sample();
      n_cmp++;
      if (got !== s.exp) begin
        n_err++;
        $display("FAIL %s step %0d: got %h expected %h", tag, idx, got, s.exp);
      end
      idx++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      opcode = 4'($urandom); mem_ready = 1'($urandom); zero = 1'($urandom);
      #1;
      n_cmp++;
      if (sample() !== obs_t'(0)) begin
        n_err++;
        $display("FAIL reset_outputs: got %h expected 0", sample());
      end
      @(negedge clk);
    end
    reset = 1'b0;
    model_instr(4'd13, 1'b0, 0, 0);
    run_steps("first_after_reset", q.size() - 1);
    q.delete();
    do_reset();
  endtask

  task automatic test_add();
    do_reset();
    model_instr(4'd2, 1'b0, 0, 0);
    run_steps("add", 0);
  endtask

  task automatic test_lw_wait();
    do_reset();
    model_instr(4'd0, 1'b0, 0, 3);
    run_steps("lw_wait", 0);
  endtask

  task automatic test_branches();
    model_instr(4'd11, 1'b0, 0, 0);
    model_instr(4'd12, 1'b0, 0, 0);
    model_instr(4'd11, 1'b1, 1, 0);
    model_instr(4'd12, 1'b1, 0, 0);
    run_steps("branch", 0);
  endtask

  task automatic test_timeout();
    obs_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      e = '0; e.mem_read = 1'b1;
      push(1'b0, 4'($urandom), 1'($urandom), e);
    end
    for (int i = 0; i < 4; i++) begin
      e = '0; e.state = 3'd7; e.bus_err = 1'b1;
      push(1'($urandom), 4'($urandom), 1'($urandom), e);
    end
    run_steps("timeout", 0);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (sample() !== obs_t'(0)) begin
      n_err++;
      $display("FAIL err_reset: got %h expected 0", sample());
    end
    @(negedge clk);
    do_reset();
    model_instr(4'd5, 1'b0, 0, 0);
    run_steps("after_err", 0);
  endtask

  task automatic test_ready_wins();
    do_reset();
    model_instr(4'd0, 1'b0, 4, 4);
    model_instr(4'd1, 1'b0, 4, 4);
    run_steps("ready_wins", 0);
  endtask

  task automatic test_mid_mem();
    do_reset();
    model_instr(4'd1, 1'b0, 0, 3);
    run_steps("sw_pre", 2);
    q.delete();
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (mem_write !== 1'b0 || instr_done !== 1'b0 || sample() !== obs_t'(0)) begin
      n_err++;
      $display("FAIL mid_mem_reset: got %h expected 0", sample());
    end
    @(negedge clk);
    do_reset();
    model_instr(4'd3, 1'b1, 0, 0);
    run_steps("after_mid_mem", 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 40; i++)
      model_instr(4'($urandom), 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
    run_steps("random", 0);
  endtask

`ifdef MC_CTRL_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 3; i++) model_instr(4'd13, 1'b0, 0, 0);
    run_steps("perf_j", 0);
    n_cmp++;
    if (instr_count !== 16'd3) begin
      n_err++;
      $display("FAIL instr_count: got %0d expected 3", instr_count);
    end
    n_cmp++;
    if (cycle_count !== 16'd9) begin
      n_err++;
      $display("FAIL cycle_count: got %0d expected 9", cycle_count);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_lw_wait();
    test_branches();
    test_timeout();
    test_ready_wins();
    test_mid_mem();
    test_back_to_back();
`ifdef MC_CTRL_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
